prefetch_fetcher: RTL

PREFETCH_FETCHER -- requirements
Module: prefetch_fetcher

---
 rtl/fetcher_pkg.sv | 12 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/prefetch_fetcher.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetcher_pkg.sv
// Shared types for the instruction prefetcher: FSM state encoding and perf counter width.
package fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // no bus request outstanding
        REQUEST = 2'd1,   // live request on the bus, result will be queued
        DRAIN   = 2'd2    // request outstanding but made stale by a redirect
    } fetch_state_t;

    localparam int PERF_COUNT_BITS = 16;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer: head/tail pointers, occupancy count, synchronous flush.
// Storage is not reset; consumers qualify the head with count != 0.
module fetch_queue #(
    parameter  int DEPTH      = 4,
    parameter  int WIDTH      = 24,
    localparam int PTR_BITS   = $clog2(DEPTH),
    localparam int COUNT_BITS = PTR_BITS + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [COUNT_BITS-1:0] count
);

    logic [WIDTH-1:0]    entries [DEPTH];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;

    assign head_data = entries[head];

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push && !flush)
            entries[tail] <= push_data;
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + COUNT_BITS'(push) - COUNT_BITS'(pop);
        end
    end

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction prefetcher: issues one outstanding program-memory read at a time,
// queues {pc, data} results, flushes and restarts on redirect.
// Optional perf counters are built only when FETCHER_PERF_EN is defined.
module prefetch_fetcher
    import fetcher_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 8,
    parameter int                      DATA_BITS    = 16,
    parameter int                      DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_enable,
    input  logic                       redirect_valid,
    input  logic [ADDRESS_BITS-1:0]    redirect_pc,
    output logic                       mem_read_valid,
    output logic [ADDRESS_BITS-1:0]    mem_read_address,
    input  logic                       mem_read_ready,
    input  logic [DATA_BITS-1:0]       mem_read_data,
    output logic                       instruction_valid,
    output logic [DATA_BITS-1:0]       instruction,
    output logic [ADDRESS_BITS-1:0]    instruction_pc,
    input  logic                       instruction_ready,
    output logic [PERF_COUNT_BITS-1:0] perf_fetch_count,
    output logic [PERF_COUNT_BITS-1:0] perf_stall_count
);

    localparam int COUNT_BITS = $clog2(DEPTH) + 1;
    localparam int ENTRY_BITS = ADDRESS_BITS + DATA_BITS;

    fetch_state_t            state;
    logic [ADDRESS_BITS-1:0] next_pc;
    logic [COUNT_BITS-1:0]   count;
    logic [COUNT_BITS-1:0]   count_next;
    logic [ENTRY_BITS-1:0]   head_entry;
    logic                    push;
    logic                    pop;
    logic                    has_room;

    // Redirect outranks both queue operations; stale (DRAIN) data is never pushed.
    assign push       = (state == REQUEST) && mem_read_ready && !redirect_valid;
    assign pop        = instruction_valid && instruction_ready && !redirect_valid;
    assign count_next = count + COUNT_BITS'(push) - COUNT_BITS'(pop);
    // A new request reserves a slot, so the queue can never be overrun.
    assign has_room   = count_next < COUNT_BITS'(DEPTH);

    assign instruction_valid = (count != '0);
    assign instruction       = instruction_valid ? head_entry[DATA_BITS-1:0] : '0;
    assign instruction_pc    = instruction_valid ? head_entry[ENTRY_BITS-1:DATA_BITS] : '0;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({mem_read_address, mem_read_data}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    // Request FSM with registered bus outputs; the address is held until ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            next_pc          <= RESET_PC;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
        end else if (redirect_valid) begin
            next_pc <= redirect_pc;
            if (state != IDLE && !mem_read_ready) begin
                // bus request must complete untouched; its data will be dropped
                state <= DRAIN;
            end else if (fetch_enable) begin
                state            <= REQUEST;
                mem_read_valid   <= 1'b1;
                mem_read_address <= redirect_pc;
            end else begin
                state          <= IDLE;
                mem_read_valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_enable && has_room) begin
                        state            <= REQUEST;
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= next_pc;
                    end
                end
                REQUEST: begin
                    if (mem_read_ready) begin
                        next_pc <= mem_read_address + 1'b1;
                        if (fetch_enable && has_room) begin
                            mem_read_address <= mem_read_address + 1'b1;
                        end else begin
                            state          <= IDLE;
                            mem_read_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_read_ready) begin
                        state          <= IDLE;
                        mem_read_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    mem_read_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCHER_PERF_EN
    logic [PERF_COUNT_BITS-1:0] fetch_cnt;
    logic [PERF_COUNT_BITS-1:0] stall_cnt;

    // Saturating counters: queued fetches and consumer cycles starved of an instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && fetch_cnt != '1)
                fetch_cnt <= fetch_cnt + 1'b1;
            if (instruction_ready && !instruction_valid && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign perf_fetch_count = fetch_cnt;
    assign perf_stall_count = stall_cnt;
`else
    assign perf_fetch_count = '0;
    assign perf_stall_count = '0;
`endif

endmodule
